// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1 bytes, packs little-endian 32-bit words into
// the FPU instruction memory and holds the core in reset until loading ends.
// Optional running sum of written words: define LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              prog_done_o,
  output logic              core_rst_o,
  output logic              frame_err_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             byte_valid, stop_bad;
  logic             rx_meta, rx_sync;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [31:0]      word_full;
  logic             accept;

  // The last byte is still in the shift register when the stop bit is judged.
  assign word_full = {shift, word_buf};
  assign accept    = byte_valid & ~prog_done_o;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (!rx_sync) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_sync ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift[7:1]};
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_sync) byte_valid = 1'b1;
          else         stop_bad   = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      byte_cnt     <= '0;
      word_buf     <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      prog_done_o  <= 1'b0;
      core_rst_o   <= 1'b1;
      frame_err_o  <= 1'b0;
    end else begin
      imem_we_o  <= 1'b0;
      core_rst_o <= ~prog_done_o;
      if (stop_bad && !prog_done_o) frame_err_o <= 1'b1;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= shift;
          2'd1:    word_buf[15:8]  <= shift;
          2'd2:    word_buf[23:16] <= shift;
          default: begin
            if (word_full == END_WORD) begin
              prog_done_o <= 1'b1;
            end else begin
              imem_we_o    <= 1'b1;
              imem_wdata_o <= word_full;
            end
          end
        endcase
      end
      // The last address is written once; memory full then ends loading.
      if (imem_we_o) begin
        if (&imem_addr_o) prog_done_o <= 1'b1;
        else              imem_addr_o <= imem_addr_o + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)       checksum_o <= '0;
    else if (imem_we_o) checksum_o <= checksum_o + imem_wdata_o;
  end
`endif

endmodule
